fsgninj_pipe: RTL and testbench
===============================

Name: fsgninj_pipe

Overview:
- Parametrised, pipelined successor to the FPU sign-injection unit.
- Executes fsgnj / fsgnjn / fsgnjx for every format enabled by FLEN/HEN.
- Adds a valid/ready handshake with full-throughput back-pressure, input NaN-box checking (unboxed operands become the canonical NaN), an illegal-format/op flag and a tag carried alongside each operation.
- Sits between FPU issue and the FPU result mux.

Parameters:
- FLEN, 64, datapath width; legal values 32, 64, 128. S is always supported, D when FLEN>=64, Q when FLEN==128.
- HEN, 0, 1 enables the half-precision (H) format.
- STAGES, 2, pipeline register count, >=1. Latency equals STAGES.
- TAGW, 5, width of the tag that passes through unchanged.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the operation this cycle
- X  in  FLEN  operand X (magnitude source)
- Y  in  FLEN  operand Y (sign source)
- Fmt  in  2  00=S, 01=D, 10=H, 11=Q
- OpCtrl  in  2  00 fsgnj, 01 fsgnjn, 10 fsgnjx, 11 reserved
- tag_in  in  TAGW  transaction tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- SgnRes  out  FLEN  NaN-boxed result
- Illegal  out  1  unsupported Fmt or OpCtrl=11
- tag_out  out  TAGW  tag of the result

Behaviour:
- Reset is asynchronous on reset_n low:
  - all stage valid bits clear, so out_valid=0 immediately;
  - SgnRes, Illegal and tag_out registers = 0;
  - in-flight operations are discarded, with no partial output.
- Clocking: all stage registers update on clk rising edge.
- Handshake:
  - An input transfers when in_valid & in_ready.
  - An output transfers when out_valid & out_ready.
  - Once out_valid is high, SgnRes, Illegal and tag_out hold stable until the output transfers.
- Pipeline:
  - Stage i loads when it is empty or stage i+1 (or the output, for the last stage) transfers this cycle.
  - in_ready = stage 0 loads, which is combinational from downstream occupancy and out_ready.
  - Bubbles collapse. Throughput is 1 op/cycle when out_ready=1.
  - Order is preserved. Nothing is dropped or duplicated.
- Timing: all computation is combinational before stage 0; later stages carry data only. A result accepted at edge n is offered with out_valid at edge n+STAGES-1, given no stalls.
- Format widths: L = 16/32/64/128 for H/S/D/Q.
- Format support:
  - A format is supported if it fits FLEN and, for H, HEN=1.
  - An unsupported Fmt gives Illegal=1 and SgnRes=0.
- NaN-box check, when L<FLEN:
  - An operand is boxed iff bits [FLEN-1:L] are all ones.
  - Unboxed X is replaced by the canonical NaN of format L (H 7E00, S 7FC00000, D 7FF8000000000000, Q 7FFF8 followed by zeros).
  - Unboxed Y is replaced the same way, which makes its sign 0.
  - When L==FLEN, no check is done.
- Sign: Xs = X'[L-1], Ys = Y'[L-1]. ResSgn = (OpCtrl[1] ? Xs : OpCtrl[0]) ^ Ys.
- Result:
  - bits [L-2:0] come from X';
  - bit L-1 = ResSgn;
  - bits [FLEN-1:L] are all ones.
- OpCtrl=11 gives Illegal=1 and SgnRes=0; the operation still flows through the pipe in order.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle with the pipe full is legal; occupancy is unchanged.
  - in_valid while reset_n is low is ignored, and in_ready=0 during reset.

Test Plan:
- FLEN=64, STAGES=2, fsgnj S, X=FFFFFFFF3F800000, Y=FFFFFFFFBF800000 -> SgnRes=FFFFFFFFBF800000, Illegal=0, out_valid 2 cycles after accept, tag preserved.
- fsgnjx D, X=C000000000000000, Y=8000000000000000 -> 4000000000000000. Then fsgnjn D, X=4000000000000000, Y=0 -> C000000000000000.
- Unboxed S: X=000000003F800000, Y=FFFFFFFF00000000, fsgnjn -> FFFFFFFFFFC00000. Unboxed Y with X boxed 1.0, fsgnj -> FFFFFFFF3F800000.
- Back-pressure: issue 4 back-to-back ops with tags 1..4 while out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - SgnRes and tag_out stay stable while stalled.
  - After release, tags appear in order 1,2,3,4 with no gaps once streaming.
- Fmt=Q on FLEN=64 -> Illegal=1, SgnRes=0. OpCtrl=11 on S -> Illegal=1. HEN=0 with Fmt=H -> Illegal=1.
- Assert reset_n low mid-stream with 2 ops in flight -> out_valid=0 without waiting for a clock edge, and no stale result after reset_n rises. The first post-reset op completes with its own tag.

Source files
------------

// File: rtl/fsgninj_pipe.sv
// Pipelined FP sign-injection unit (fsgnj/fsgnjn/fsgnjx) for H/S/D/Q formats,
// with valid/ready back-pressure, NaN-box checking and a pass-through tag.
module fsgninj_pipe #(
  parameter int FLEN   = 64,
  parameter int HEN    = 0,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] X,
  input  logic [FLEN-1:0] Y,
  input  logic [1:0]      Fmt,
  input  logic [1:0]      OpCtrl,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] SgnRes,
  output logic            Illegal,
  output logic [TAGW-1:0] tag_out
);

  logic [FLEN-1:0] w_fmt_res [4];
  logic [3:0]      w_fmt_sup;
  logic [FLEN-1:0] w_res;
  logic            w_illegal;

  // Index gi equals the Fmt encoding: 0=S, 1=D, 2=H, 3=Q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fmt
    localparam int LW = (gi == 0) ? 32 : (gi == 1) ? 64 : (gi == 2) ? 16 : 128;
    localparam int EW = (gi == 0) ? 8  : (gi == 1) ? 11 : (gi == 2) ? 5  : 15;
    localparam bit SUP = (LW <= FLEN) && ((gi != 2) || (HEN != 0));

    if (!SUP) begin : g_unsup
      assign w_fmt_sup[gi] = 1'b0;
      assign w_fmt_res[gi] = '0;
    end else if (LW < FLEN) begin : g_boxed
      localparam logic [LW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(LW-2-EW){1'b0}}};
      logic [LW-1:0] w_xp;
      logic [LW-1:0] w_yp;
      logic          w_sgn;
      assign w_xp  = (&X[FLEN-1:LW]) ? X[LW-1:0] : QNAN;
      assign w_yp  = (&Y[FLEN-1:LW]) ? Y[LW-1:0] : QNAN;
      assign w_sgn = (OpCtrl[1] ? w_xp[LW-1] : OpCtrl[0]) ^ w_yp[LW-1];
      assign w_fmt_sup[gi] = 1'b1;
      assign w_fmt_res[gi] = {{(FLEN-LW){1'b1}}, w_sgn, w_xp[LW-2:0]};
    end else begin : g_full
      logic w_sgn;
      assign w_sgn = (OpCtrl[1] ? X[LW-1] : OpCtrl[0]) ^ Y[LW-1];
      assign w_fmt_sup[gi] = 1'b1;
      assign w_fmt_res[gi] = {w_sgn, X[LW-2:0]};
    end
  end

  assign w_illegal = !w_fmt_sup[Fmt] || (OpCtrl == 2'b11);
  assign w_res     = w_illegal ? '0 : w_fmt_res[Fmt];

  logic [STAGES-1:0] r_valid;
  logic [FLEN-1:0]   r_res [STAGES];
  logic              r_ill [STAGES];
  logic [TAGW-1:0]   r_tag [STAGES];
  logic [STAGES-1:0] w_load;

  // A stage may load when it or any stage after it is empty, or the output drains.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_load
    assign w_load[gi] = out_ready | ~(&r_valid[STAGES-1:gi]);
  end

  assign in_ready = reset_n & w_load[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_res[i] <= '0;
        r_ill[i] <= 1'b0;
        r_tag[i] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_res[0] <= w_res;
          r_ill[0] <= w_illegal;
          r_tag[0] <= tag_in;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_res[i] <= r_res[i-1];
            r_ill[i] <= r_ill[i-1];
            r_tag[i] <= r_tag[i-1];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign SgnRes    = r_res[STAGES-1];
  assign Illegal   = r_ill[STAGES-1];
  assign tag_out   = r_tag[STAGES-1];

endmodule

// File: tb/tb_fsgninj_pipe.sv
// Self-checking bench for fsgninj_pipe (FLEN=64, HEN=0, STAGES=2): directed
// cases followed by randomized traffic against a format-level reference model.
module tb_fsgninj_pipe;
  localparam int FLEN = 64;
  localparam int HEN  = 0;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [FLEN-1:0] X, Y;
  logic [1:0]      Fmt, OpCtrl;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [FLEN-1:0] SgnRes;
  logic            Illegal;
  logic [TAGW-1:0] tag_out;

  fsgninj_pipe #(.FLEN(FLEN), .HEN(HEN), .STAGES(2), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .Fmt(Fmt), .OpCtrl(OpCtrl), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .SgnRes(SgnRes),
    .Illegal(Illegal), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] q_res[$];
  logic        q_ill[$];
  logic [4:0]  q_tag[$];
  logic [63:0] cur_res;
  logic        cur_ill;
  logic        acc;
  logic        prev_stall;
  logic [63:0] prev_res;
  logic        prev_ill;
  logic [4:0]  prev_tag;
  logic [4:0]  k;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, got, exp);
    end
  endtask

  // Reference: derive width L from Fmt, unbox via masks, rebuild the result arithmetically.
  function automatic void model(input logic [63:0] x, input logic [63:0] y,
                                input logic [1:0] fmt, input logic [1:0] op,
                                output logic [63:0] r, output logic ill);
    int L;
    logic [63:0] nan, hi, xb, yb;
    logic s;
    case (fmt)
      2'd0: begin L = 32;  nan = 64'h7FC00000; end
      2'd1: begin L = 64;  nan = 64'h7FF8000000000000; end
      2'd2: begin L = 16;  nan = 64'h7E00; end
      default: begin L = 128; nan = 64'h0; end
    endcase
    ill = (L > FLEN) || (fmt == 2'd2 && HEN == 0) || (op == 2'd3);
    r = '0;
    if (!ill) begin
      hi = ~((64'd1 << L) - 64'd1);
      xb = ((x & hi) == hi) ? (x & ~hi) : nan;
      yb = ((y & hi) == hi) ? (y & ~hi) : nan;
      s  = (op[1] ? xb[L-1] : op[0]) ^ yb[L-1];
      r  = hi | ({63'd0, s} << (L - 1)) | (xb & ((64'd1 << (L - 1)) - 64'd1));
    end
  endfunction

  task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic [1:0] f,
                       input logic [1:0] o, input logic [4:0] t);
    X = x; Y = y; Fmt = f; OpCtrl = o; tag_in = t;
  endtask

  // One clock: sample at negedge+1, score outputs, record accepts, wait for next negedge.
  task automatic tick();
    #1;
    acc = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_res", SgnRes, prev_res);
      chk("hold_ill", {63'd0, Illegal}, {63'd0, prev_ill});
      chk("hold_tag", {59'd0, tag_out}, {59'd0, prev_tag});
    end
    if (out_valid && out_ready) begin
      if (q_res.size() == 0) begin
        chk("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("res", SgnRes, q_res.pop_front());
        chk("ill", {63'd0, Illegal}, {63'd0, q_ill.pop_front()});
        chk("tag", {59'd0, tag_out}, {59'd0, q_tag.pop_front()});
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_res = SgnRes; prev_ill = Illegal; prev_tag = tag_out;
    if (in_valid && in_ready) begin
      q_res.push_back(cur_res); q_ill.push_back(cur_ill); q_tag.push_back(tag_in);
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [1:0] f,
                      input logic [1:0] o, input logic [4:0] t,
                      input logic [63:0] er, input logic ei);
    drive(x, y, f, o, t);
    cur_res = er; cur_ill = ei;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) break;
    end
    chk("accept_bound", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q_res.size() != 0; i++) tick();
    chk("drain_bound", q_res.size(), 64'd0);
  endtask

  initial begin
    logic [63:0] rx, ry, er;
    logic [1:0]  rf, ro;
    logic        ei;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; prev_stall = 1'b0;
    drive('0, '0, 2'd0, 2'd0, '0);
    cur_res = '0; cur_ill = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_res", SgnRes, 64'd0);
    chk("rst_ill", {63'd0, Illegal}, 64'd0);
    chk("rst_tag", {59'd0, tag_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Latency and tag on a boxed S fsgnj.
    send(64'hFFFFFFFF3F800000, 64'hFFFFFFFFBF800000, 2'd0, 2'd0, 5'd9, 64'hFFFFFFFFBF800000, 1'b0);
    #1 chk("lat_edge_n", {63'd0, out_valid}, 64'd0);
    tick();
    #1 chk("lat_edge_n1", {63'd0, out_valid}, 64'd1);
    chk("lat_res", SgnRes, 64'hFFFFFFFFBF800000);
    chk("lat_tag", {59'd0, tag_out}, 64'd9);
    tick();

    send(64'hC000000000000000, 64'h8000000000000000, 2'd1, 2'd2, 5'd2, 64'h4000000000000000, 1'b0);
    send(64'h4000000000000000, 64'h0, 2'd1, 2'd1, 5'd3, 64'hC000000000000000, 1'b0);
    send(64'h000000003F800000, 64'hFFFFFFFF00000000, 2'd0, 2'd1, 5'd4, 64'hFFFFFFFFFFC00000, 1'b0);
    send(64'hFFFFFFFF3F800000, 64'h0000000080000000, 2'd0, 2'd0, 5'd5, 64'hFFFFFFFF3F800000, 1'b0);
    send(64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 2'd3, 2'd0, 5'd6, 64'h0, 1'b1);
    send(64'hFFFFFFFF3F800000, 64'hFFFFFFFFBF800000, 2'd0, 2'd3, 5'd7, 64'h0, 1'b1);
    send(64'hFFFFFFFFFFFF3C00, 64'hFFFFFFFFFFFFBC00, 2'd2, 2'd0, 5'd8, 64'h0, 1'b1);
    drain();

    // Back-pressure: four back-to-back ops, output stalled for three cycles.
    out_ready = 1'b0;
    k = 5'd1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) out_ready = 1'b1;
      in_valid = (k <= 5'd4);
      if (in_valid) begin
        drive({32'hFFFFFFFF, $urandom}, {32'hFFFFFFFF, $urandom}, 2'd0, 2'd2, k);
        model(X, Y, Fmt, OpCtrl, cur_res, cur_ill);
      end
      if (c == 2) begin
        #1;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_accepts", {59'd0, k}, 64'd3);
        chk("bp_head_tag", {59'd0, tag_out}, 64'd1);
      end
      if (c >= 3) begin
        #1 chk("bp_stream", {63'd0, out_valid}, 64'd1);
      end
      tick();
      if (acc) k = k + 5'd1;
    end
    drain();

    // Asynchronous reset with two results in flight.
    out_ready = 1'b0;
    send(64'hFFFFFFFF3F800000, 64'h0, 2'd0, 2'd0, 5'd10, 64'hFFFFFFFF3F800000, 1'b0);
    send(64'hFFFFFFFF3F800000, 64'h0, 2'd0, 2'd1, 5'd11, 64'hFFFFFFFFBF800000, 1'b0);
    #1 chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("async_rst_tag", {59'd0, tag_out}, 64'd0);
    q_res.delete(); q_ill.delete(); q_tag.delete();
    prev_stall = 1'b0;
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(64'hFFFFFFFF40000000, 64'hFFFFFFFF80000000, 2'd0, 2'd0, 5'd7, 64'hFFFFFFFFC0000000, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) tick();
    #1 chk("post_rst_idle", {63'd0, out_valid}, 64'd0);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      rf = 2'($urandom_range(0, 3));
      ro = 2'($urandom_range(0, 3));
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rx[63:32] = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) != 0) ry[63:32] = 32'hFFFFFFFF;
      if ($urandom_range(0, 1) != 0) rx[31:16] = 16'hFFFF;
      drive(rx, ry, rf, ro, 5'($urandom));
      model(rx, ry, rf, ro, er, ei);
      cur_res = er; cur_ill = ei;
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
